// File: rtl/nav_sequencer_if.sv
// Command-layer handshake between the maze-solving command FSM and nav_sequencer.
// The command FSM drives the start pulses and operands; the sequencer answers with mv_cmplt.
interface nav_sequencer_if;
  logic              strt_hdng;
  logic              strt_mv;
  logic              stp_lft;
  logic              stp_rght;
  logic signed [11:0] cmd_hdng;
  logic              mv_cmplt;

  modport master (
    output strt_hdng, strt_mv, stp_lft, stp_rght, cmd_hdng,
    input  mv_cmplt
  );

  modport slave (
    input  strt_hdng, strt_mv, stp_lft, stp_rght, cmd_hdng,
    output mv_cmplt
  );
endinterface

// File: rtl/nav_sequencer.sv
// Command-level sequencer in front of the heading PID: turns to a heading or moves
// forward with a speed ramp, decelerating at obstacles or requested side openings.
module nav_sequencer #(
  parameter logic [10:0] SPD_INC       = 11'h010,
  parameter logic [10:0] MAX_SPD       = 11'h2A0,
  parameter int          OPN_DEC_SHIFT = 1,
  parameter int          OBS_DEC_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst,
  nav_sequencer_if.slave     cmd,
  input  logic               hdng_vld,
  input  logic               at_hdng,
  input  logic               lft_opn,
  input  logic               rght_opn,
  input  logic               frwrd_opn,
  output logic               moving,
  output logic signed [11:0] dsrd_hdng,
  output logic [10:0]        frwrd_spd,
  output logic               en_fusion
);

  localparam logic [10:0] OPN_STEP  = 11'(SPD_INC << OPN_DEC_SHIFT);
  localparam logic [10:0] OBS_STEP  = 11'(SPD_INC << OBS_DEC_SHIFT);
  localparam logic [10:0] FUSION_TH = MAX_SPD >> 1;

  typedef enum logic [1:0] {IDLE, HDNG, RAMP, DECEL} state_t;

  state_t             state, state_nxt;
  logic               moving_nxt;
  logic signed [11:0] hdng_nxt;
  logic [10:0]        spd_nxt;
  logic               cmplt_nxt;
  logic               stp_lft_q, stp_lft_nxt;
  logic               stp_rght_q, stp_rght_nxt;
  logic [10:0]        dec_step, dec_step_nxt;
  logic               lft_opn_q, rght_opn_q;
  logic               opn_hit;

  // Saturating ramp-up, computed one bit wider so the sum can never wrap.
  function automatic logic [10:0] ramp_up(input logic [10:0] spd);
    logic [11:0] sum;
    sum = {1'b0, spd} + {1'b0, SPD_INC};
    if (sum > {1'b0, MAX_SPD}) return MAX_SPD;
    return sum[10:0];
  endfunction

  function automatic logic [10:0] ramp_dn(input logic [10:0] spd, input logic [10:0] step);
    if (spd <= step) return '0;
    return spd - step;
  endfunction

  assign en_fusion = (frwrd_spd > FUSION_TH);

  assign opn_hit = (stp_lft_q  && lft_opn  && !lft_opn_q) ||
                   (stp_rght_q && rght_opn && !rght_opn_q);

  always_comb begin
    state_nxt    = state;
    hdng_nxt     = dsrd_hdng;
    spd_nxt      = frwrd_spd;
    cmplt_nxt    = 1'b0;
    stp_lft_nxt  = stp_lft_q;
    stp_rght_nxt = stp_rght_q;
    dec_step_nxt = dec_step;
    case (state)
      IDLE: begin
        spd_nxt = '0;
        if (cmd.strt_hdng) begin
          hdng_nxt  = cmd.cmd_hdng;
          state_nxt = HDNG;
        end else if (cmd.strt_mv) begin
          stp_lft_nxt  = cmd.stp_lft;
          stp_rght_nxt = cmd.stp_rght;
          state_nxt    = RAMP;
        end
      end
      HDNG: begin
        spd_nxt = '0;
        if (at_hdng && hdng_vld) begin
          cmplt_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      RAMP: begin
        if (hdng_vld) spd_nxt = ramp_up(frwrd_spd);
        // An obstacle outranks a requested opening stop.
        if (!frwrd_opn) begin
          dec_step_nxt = OBS_STEP;
          state_nxt    = DECEL;
        end else if (opn_hit) begin
          dec_step_nxt = OPN_STEP;
          state_nxt    = DECEL;
        end
      end
      DECEL: begin
        if (frwrd_spd == '0) begin
          cmplt_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          if (hdng_vld) spd_nxt = ramp_dn(frwrd_spd, dec_step);
          if (!frwrd_opn) dec_step_nxt = OBS_STEP;
        end
      end
      default: state_nxt = IDLE;
    endcase
    moving_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      moving       <= 1'b0;
      dsrd_hdng    <= '0;
      frwrd_spd    <= '0;
      cmd.mv_cmplt <= 1'b0;
      stp_lft_q    <= 1'b0;
      stp_rght_q   <= 1'b0;
      dec_step     <= '0;
      lft_opn_q    <= 1'b0;
      rght_opn_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      moving       <= moving_nxt;
      dsrd_hdng    <= hdng_nxt;
      frwrd_spd    <= spd_nxt;
      cmd.mv_cmplt <= cmplt_nxt;
      stp_lft_q    <= stp_lft_nxt;
      stp_rght_q   <= stp_rght_nxt;
      dec_step     <= dec_step_nxt;
      lft_opn_q    <= lft_opn;
      rght_opn_q   <= rght_opn;
    end
  end

endmodule

// File: tb/tb_nav_sequencer.sv
// Scoreboard bench for nav_sequencer: directed scenarios followed by random traffic,
// checked against a command-level behavioural model of the sequencer.
module tb_nav_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        hdng_vld, at_hdng, lft_opn, rght_opn, frwrd_opn;
  logic        moving;
  logic signed [11:0] dsrd_hdng;
  logic [10:0] frwrd_spd;
  logic        en_fusion;

  nav_sequencer_if cmd_if ();

  nav_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if),
    .hdng_vld  (hdng_vld),
    .at_hdng   (at_hdng),
    .lft_opn   (lft_opn),
    .rght_opn  (rght_opn),
    .frwrd_opn (frwrd_opn),
    .moving    (moving),
    .dsrd_hdng (dsrd_hdng),
    .frwrd_spd (frwrd_spd),
    .en_fusion (en_fusion)
  );

  always #5 clk = ~clk;

  // Pending stimulus for the next cycle
  logic        d_rst, d_sh, d_sm, d_sl, d_sr, d_vld, d_at, d_lo, d_ro, d_fo;
  logic [11:0] d_cmd;

  typedef struct {
    logic        mv;
    logic [11:0] hd;
    logic [10:0] spd;
    logic        cm;
    logic        fu;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: what the sequencer is doing, as plain integers
  typedef enum {M_REST, M_TURN, M_ACCEL, M_BRAKE} mode_t;
  mode_t       m_mode;
  int          m_spd, m_step;
  logic [11:0] m_hd;
  logic        m_cm, m_wl, m_wr, m_pl, m_pr;

  task automatic model_step();
    int nspd;
    if (d_rst) begin
      m_mode = M_REST; m_spd = 0; m_hd = '0; m_cm = 0; m_wl = 0; m_wr = 0;
      m_step = 0; m_pl = 0; m_pr = 0;
      return;
    end
    m_cm = 0;
    case (m_mode)
      M_REST: begin
        m_spd = 0;
        if (d_sh) begin m_hd = d_cmd; m_mode = M_TURN; end
        else if (d_sm) begin m_wl = d_sl; m_wr = d_sr; m_mode = M_ACCEL; end
      end
      M_TURN: if (d_at && d_vld) begin m_cm = 1; m_mode = M_REST; end
      M_ACCEL: begin
        if (d_vld) m_spd = (m_spd + 16 > 672) ? 672 : m_spd + 16;
        if (!d_fo) begin m_step = 64; m_mode = M_BRAKE; end
        else if ((m_wl && d_lo && !m_pl) || (m_wr && d_ro && !m_pr)) begin
          m_step = 32; m_mode = M_BRAKE;
        end
      end
      M_BRAKE: begin
        if (m_spd == 0) begin m_cm = 1; m_mode = M_REST; end
        else begin
          nspd = m_spd - m_step;
          if (d_vld) m_spd = (nspd < 0) ? 0 : nspd;
          if (!d_fo) m_step = 64;
        end
      end
      default: m_mode = M_REST;
    endcase
    m_pl = d_lo;
    m_pr = d_ro;
  endtask

  // Apply pending stimulus away from the sampling edge and queue the expected response
  task automatic tick();
    exp_t e;
    @(negedge clk);
    rst = d_rst;
    cmd_if.strt_hdng = d_sh; cmd_if.strt_mv = d_sm;
    cmd_if.stp_lft = d_sl;   cmd_if.stp_rght = d_sr;
    cmd_if.cmd_hdng = d_cmd;
    hdng_vld = d_vld; at_hdng = d_at; lft_opn = d_lo; rght_opn = d_ro; frwrd_opn = d_fo;
    model_step();
    e.mv  = (m_mode != M_REST);
    e.hd  = m_hd;
    e.spd = 11'(m_spd);
    e.cm  = m_cm;
    e.fu  = (m_spd > 336);
    exp_q.push_back(e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: outputs are presented every cycle just after the active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("moving",    {31'b0, moving},    {31'b0, e.mv});
        chk("dsrd_hdng", {20'b0, dsrd_hdng}, {20'b0, e.hd});
        chk("frwrd_spd", {21'b0, frwrd_spd}, {21'b0, e.spd});
        chk("mv_cmplt",  {31'b0, cmd_if.mv_cmplt}, {31'b0, e.cm});
        chk("en_fusion", {31'b0, en_fusion}, {31'b0, e.fu});
      end
    end
  end

  task automatic quiet();
    d_rst = 0; d_sh = 0; d_sm = 0; d_sl = 0; d_sr = 0; d_vld = 0; d_at = 0;
    d_lo = 0; d_ro = 0; d_fo = 1; d_cmd = '0;
  endtask

  initial begin
    m_mode = M_REST; m_spd = 0; m_step = 0; m_hd = '0; m_cm = 0;
    m_wl = 0; m_wr = 0; m_pl = 0; m_pr = 0;
    quiet();
    rst = 1; cmd_if.strt_hdng = 0; cmd_if.strt_mv = 0; cmd_if.stp_lft = 0;
    cmd_if.stp_rght = 0; cmd_if.cmd_hdng = '0;
    hdng_vld = 0; at_hdng = 0; lft_opn = 0; rght_opn = 0; frwrd_opn = 1;

    d_rst = 1; ticks(2); d_rst = 0; ticks(1);

    // Turn to heading: at_hdng alone never completes
    d_cmd = 12'h3FF; d_sh = 1; tick(); d_sh = 0;
    d_at = 1; ticks(5);
    d_vld = 1; tick();
    d_vld = 0; d_at = 0; ticks(3);

    // Full ramp to saturation, then obstacle stop
    d_sm = 1; tick(); d_sm = 0;
    d_vld = 1; ticks(50);
    d_fo = 0; ticks(13);
    d_fo = 1; d_vld = 0; ticks(3);

    // Opening already present at start is ignored; a fresh edge stops the move
    d_lo = 1; ticks(2);
    d_sm = 1; d_sl = 1; tick(); d_sm = 0; d_sl = 0;
    d_vld = 1; ticks(20);
    d_vld = 0; d_lo = 0; tick();
    d_lo = 1; tick();
    d_vld = 1; ticks(12);
    d_vld = 0; d_lo = 0; ticks(3);

    // Simultaneous commands: turn wins; move during turn is dropped
    d_cmd = 12'h800; d_sh = 1; d_sm = 1; tick(); d_sh = 0; d_sm = 0;
    d_vld = 1; ticks(2);
    d_vld = 0; d_sm = 1; tick(); d_sm = 0;
    d_at = 1; d_vld = 1; tick();
    d_at = 0; d_vld = 0; ticks(2);

    // Reset mid-ramp, then restart from zero
    d_sm = 1; tick(); d_sm = 0;
    d_vld = 1; ticks(25);
    d_rst = 1; tick(); d_rst = 0; d_vld = 0; ticks(2);
    d_sm = 1; tick(); d_sm = 0;
    d_vld = 1; ticks(4);
    d_fo = 0; d_vld = 0; tick(); d_fo = 1; ticks(4);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      d_rst = ($urandom_range(0, 599) == 0);
      d_sh  = ($urandom_range(0, 24) == 0);
      d_sm  = ($urandom_range(0, 7) == 0);
      d_sl  = 1'($urandom);
      d_sr  = 1'($urandom);
      d_cmd = 12'($urandom);
      d_vld = ($urandom_range(0, 2) == 0);
      d_at  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 14) == 0) d_lo = ~d_lo;
      if ($urandom_range(0, 14) == 0) d_ro = ~d_ro;
      d_fo  = ($urandom_range(0, 59) != 0);
      tick();
    end

    quiet(); ticks(2);
    repeat (3) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nav_sequencer.md
Name: nav_sequencer

Overview:
Command-level sequencer for the heading PID. Accepts "turn to heading" and "move forward" commands from the maze-solving command layer and drives the PID control inputs `moving`, `dsrd_hdng` and `frwrd_spd`. It ramps forward speed up and down on heading-valid ticks and signals command completion. It sits between the command FSM and the PID; the PID's `at_hdng` feeds back into it.

Parameters:
SPD_INC, 11'h010, forward-speed increment applied per `hdng_vld` tick while ramping up.
MAX_SPD, 11'h2A0, forward-speed ceiling during ramp-up.
OPN_DEC_SHIFT, 1, opening-stop decel step = SPD_INC << OPN_DEC_SHIFT.
OBS_DEC_SHIFT, 2, obstacle-stop decel step = SPD_INC << OBS_DEC_SHIFT.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high; one clock; all state updates on posedge clk
strt_hdng  in  1  single-cycle pulse: begin turn to cmd_hdng
strt_mv  in  1  single-cycle pulse: begin forward move
stp_lft  in  1  qualifier with strt_mv: stop at next left opening
stp_rght  in  1  qualifier with strt_mv: stop at next right opening
cmd_hdng  in  12  signed target heading, sampled with strt_hdng
hdng_vld  in  1  new heading sample tick (ramp timing)
at_hdng  in  1  PID heading-error-small flag
lft_opn  in  1  left-side opening sensed
rght_opn  in  1  right-side opening sensed
frwrd_opn  in  1  path ahead clear (0 = obstacle)
moving  out  1  PID enable
dsrd_hdng  out  12  signed desired heading to PID
frwrd_spd  out  11  unsigned forward speed to PID
mv_cmplt  out  1  single-cycle pulse: current command finished
en_fusion  out  1  high when frwrd_spd > MAX_SPD/2

Behaviour:
- Reset values: state=IDLE, moving=0, dsrd_hdng=0, frwrd_spd=0, mv_cmplt=0, latched stop flags=0, decel step=0, lft/rght_opn edge regs=0. Reset mid-command aborts to IDLE on that edge; no mv_cmplt.
- All outputs are registered. en_fusion is derived combinationally from the frwrd_spd register.
- States: IDLE, HDNG, RAMP, DECEL.
- IDLE:
  - moving=0, frwrd_spd=0.
  - strt_hdng: dsrd_hdng<=cmd_hdng, go to HDNG.
  - strt_mv: latch stp_lft/stp_rght, go to RAMP.
  - Both asserted on the same cycle: strt_hdng wins and strt_mv is dropped.
  - Commands arriving outside IDLE are ignored.
- HDNG:
  - moving=1, frwrd_spd held 0.
  - Exit when at_hdng=1 AND hdng_vld=1 on the same cycle: mv_cmplt=1 for one cycle, go to IDLE, moving=0 next cycle.
  - at_hdng without hdng_vld does not complete.
- RAMP:
  - moving=1.
  - Each hdng_vld: frwrd_spd <= min(frwrd_spd+SPD_INC, MAX_SPD). Compute in 12 bits and saturate; no wrap.
  - Exit priority, evaluated every cycle:
    1. frwrd_opn=0: decel step = SPD_INC<<OBS_DEC_SHIFT, go to DECEL.
    2. Latched stp_lft and rising edge of lft_opn (registered previous value was 0, current 1), or latched stp_rght and rising edge of rght_opn: decel step = SPD_INC<<OPN_DEC_SHIFT, go to DECEL.
  - An opening already present when the move starts does not trigger. The edge regs sample every cycle in all states.
- DECEL:
  - moving=1.
  - Each hdng_vld: frwrd_spd <= frwrd_spd - step, floored at 0 (no underflow).
  - frwrd_opn=0 during an opening decel upgrades the step to the obstacle step from the next tick.
  - When the frwrd_spd register is 0 in DECEL: mv_cmplt pulse, go to IDLE.
  - If DECEL is entered with frwrd_spd=0, complete on the next cycle.
- mv_cmplt is never asserted for two consecutive cycles.
- dsrd_hdng holds its value through moves and changes only on an accepted strt_hdng.

Test Plan:
- Reset then strt_hdng with cmd_hdng=12'h3FF; at_hdng=1 with hdng_vld=0 for 5 cycles, then hdng_vld=1 -> dsrd_hdng=12'h3FF, moving=1 the cycle after strt_hdng, mv_cmplt one pulse on the cycle after the qualifying hdng_vld, then moving=0.
- strt_mv (no stops), frwrd_opn=1, 50 hdng_vld ticks -> frwrd_spd steps 16,32,…, saturates at 672 after 42 ticks and holds; en_fusion rises when frwrd_spd first exceeds 336 (frwrd_spd=352).
- At speed 672, drop frwrd_opn -> 64-step decel: 608,…,32,0 (11 ticks), mv_cmplt single pulse, moving=0.
- strt_mv with stp_lft=1 while lft_opn already 1 -> no stop; lft_opn 0→1 at speed 320 -> decel by 32 per tick to 0 in 10 ticks, then mv_cmplt.
- strt_hdng and strt_mv same cycle -> HDNG entered, frwrd_spd stays 0; strt_mv while in HDNG ignored.
- rst=1 mid-RAMP at speed 400 -> next edge frwrd_spd=0, moving=0, no mv_cmplt; later strt_mv restarts from 0.
